// File: rtl/aes_round_tail.sv
// AES-128 round back-end: ShiftRows, MixColumns (skipped on the final round), AddRoundKey,
// registered behind a valid/ready handshake with an optional skid slot for full throughput.
module aes_round_tail #(
  parameter int SKID_EN = 1,
  parameter int TAG_W   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [127:0]     state_i,
  input  logic [127:0]     rkey_i,
  input  logic             last_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [127:0]     state_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam bit LP_SKID = (SKID_EN != 0);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // a valid side holds its payload stable until that edge.

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [127:0] w_next;
  logic         w_in_fire;
  logic         w_out_fire;

  logic             r_out_valid;
  logic [127:0]     r_out_state;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_skid_valid;
  logic [127:0]     r_skid_state;
  logic [TAG_W-1:0] r_skid_tag;

  // Byte n sits at [127-8n -: 8]; row r of column c is byte r+4c.
  always_comb begin
    w_sr = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_sr[127-8*(r+4*c) -: 8] = state_i[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
  end

  always_comb begin
    w_mc = '0;
    for (int c = 0; c < 4; c++) begin
      w_mc[127-32*c -: 32] = mix_col(w_sr[127-32*c -: 32]);
    end
  end

  assign w_next     = (last_i ? w_sr : w_mc) ^ rkey_i;
  assign ready_o    = LP_SKID ? !r_skid_valid : (!r_out_valid || ready_i);
  assign w_in_fire  = valid_i && ready_o;
  assign w_out_fire = r_out_valid && ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_valid  <= 1'b0;
      r_out_state  <= '0;
      r_out_tag    <= '0;
      r_skid_valid <= 1'b0;
      r_skid_state <= '0;
      r_skid_tag   <= '0;
    end else if (flush_i) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_out_valid || w_out_fire) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_state  <= r_skid_state;
        r_out_tag    <= r_skid_tag;
        r_skid_valid <= w_in_fire;
        if (w_in_fire) begin
          r_skid_state <= w_next;
          r_skid_tag   <= tag_i;
        end
      end else begin
        r_out_valid <= w_in_fire;
        if (w_in_fire) begin
          r_out_state <= w_next;
          r_out_tag   <= tag_i;
        end
      end
    end else if (w_in_fire && LP_SKID) begin
      // Output slot stalled: park the new entry behind it.
      r_skid_valid <= 1'b1;
      r_skid_state <= w_next;
      r_skid_tag   <= tag_i;
    end
  end

  assign valid_o = r_out_valid;
  assign state_o = r_out_state;
  assign tag_o   = r_out_tag;

endmodule

// File: tb/tb_aes_round_tail.sv
// Directed bench for aes_round_tail (SKID_EN=1): FIPS-197 round vectors, backpressure,
// throughput, flush and asynchronous reset.
module tb_aes_round_tail;

  localparam int TAG_W = 4;
  localparam int W     = 128 + TAG_W;

  localparam logic [127:0] V1 = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
  localparam logic [127:0] K1 = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] E1 = 128'ha49c7ff2_689f352b_6b5bea43_026a5049;
  localparam logic [127:0] V2 = 128'he9098972_cb31075f_3d327d94_af2e2cb5;
  localparam logic [127:0] K2 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] E2 = 128'h3925841d_02dc09fb_dc118597_196a0b32;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             flush_i = 1'b0;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic [127:0]     state_i = '0;
  logic [127:0]     rkey_i = '0;
  logic             last_i = 1'b0;
  logic [TAG_W-1:0] tag_i = '0;
  logic             valid_o;
  logic             ready_i = 1'b0;
  logic [127:0]     state_o;
  logic [TAG_W-1:0] tag_o;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  aes_round_tail #(.SKID_EN(1), .TAG_W(TAG_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .state_i(state_i), .rkey_i(rkey_i), .last_i(last_i), .tag_i(tag_i),
    .valid_o(valid_o), .ready_i(ready_i), .state_o(state_o), .tag_o(tag_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  // Drivers (called at the falling edge)
  task automatic set_in(input logic v, input logic [127:0] s, input logic [127:0] k,
                        input logic l, input logic [TAG_W-1:0] t);
    valid_i = v;
    state_i = s;
    rkey_i  = k;
    last_i  = l;
    tag_i   = t;
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    set_in(1'b0, '0, '0, 1'b0, '0);
    step();
    checks += 4;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    if (state_o !== 128'h0) begin errors++; $display("FAIL reset_state: got %h want 0", state_o); end
    if (tag_o !== '0) begin errors++; $display("FAIL reset_tag: got %h want 0", tag_o); end
    if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    rst_i = 1'b0;
    step();
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", valid_o); end
  endtask

  task automatic test_vector(input string name, input logic [127:0] s, input logic [127:0] k,
                             input logic l, input logic [TAG_W-1:0] t, input logic [127:0] e);
    ready_i = 1'b0;
    set_in(1'b1, s, k, l, t);
    #1;
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL %s_ready: got %b want 1", name, ready_o); end
    step();
    set_in(1'b0, '0, '0, 1'b0, '0);
    checks += 3;
    if (valid_o !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b want 1", name, valid_o); end
    if (state_o !== e) begin errors++; $display("FAIL %s_state: got %h want %h", name, state_o, e); end
    if (tag_o !== t) begin errors++; $display("FAIL %s_tag: got %h want %h", name, tag_o, t); end
    step();
    checks++;
    if (valid_o !== 1'b1 || state_o !== e) begin
      errors++; $display("FAIL %s_hold: got valid=%b state=%h want 1 %h", name, valid_o, state_o, e);
    end
    ready_i = 1'b1;
    step();
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL %s_drain: got %b want 0", name, valid_o); end
  endtask

  task automatic test_round1();
    test_vector("round1", V1, K1, 1'b0, 4'h5, E1);
  endtask

  task automatic test_final();
    test_vector("final", V2, K2, 1'b1, 4'h6, E2);
  endtask

  task automatic test_identity();
    // Zero state mixes to zero; a uniform state is a fixed point of ShiftRows and MixColumns.
    test_vector("zero_state", 128'h0, K1, 1'b0, 4'h1, K1);
    test_vector("uniform", {16{8'h01}}, 128'h0, 1'b0, 4'h2, {16{8'h01}});
  endtask

  task automatic test_backpressure();
    logic in_f, out_f;
    logic [W-1:0] e;
    int n_out;
    exp_q.delete();
    ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, V1, K1, 1'b0, 4'(k + 1));
      #1;
      checks++;
      if (ready_o !== (k < 2)) begin
        errors++; $display("FAIL bp_ready_%0d: got %b want %b", k, ready_o, (k < 2));
      end
      if (valid_i && ready_o) exp_q.push_back({tag_i, E1});
      if (k == 2) begin
        checks++;
        if (valid_o !== 1'b1 || tag_o !== 4'h1) begin
          errors++; $display("FAIL bp_head: got valid=%b tag=%h want 1 1", valid_o, tag_o);
        end
      end
      step();
    end
    ready_i = 1'b1;
    n_out = 0;
    for (int cyc = 0; cyc < 20 && n_out < 3; cyc++) begin
      #1;
      in_f  = valid_i && ready_o;
      out_f = valid_o && ready_i;
      if (out_f) begin
        checks++;
        n_out++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra: got tag=%h want no output", tag_o);
        end else begin
          e = exp_q.pop_front();
          if ({tag_o, state_o} !== e) begin
            errors++; $display("FAIL bp_order: got %h want %h", {tag_o, state_o}, e);
          end
        end
      end
      if (in_f) exp_q.push_back({tag_i, E1});
      step();
      if (in_f) set_in(1'b0, '0, '0, 1'b0, '0);
    end
    checks++;
    if (n_out != 3) begin errors++; $display("FAIL bp_count: got %0d want 3", n_out); end
    checks++;
    if (valid_o !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_dup: got valid=%b left=%0d want 0 0", valid_o, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic in_f, out_f, drop, gap;
    logic [W-1:0] e;
    int sent, n_out, last_cyc;
    exp_q.delete();
    sent = 0; n_out = 0; last_cyc = -1; drop = 1'b0; gap = 1'b0;
    ready_i = 1'b1;
    for (int cyc = 0; cyc < 40 && n_out < 16; cyc++) begin
      if (sent < 16) begin
        if (sent % 2 == 1) set_in(1'b1, V2, K2, 1'b1, sent[TAG_W-1:0]);
        else               set_in(1'b1, V1, K1, 1'b0, sent[TAG_W-1:0]);
      end else begin
        set_in(1'b0, '0, '0, 1'b0, '0);
      end
      #1;
      if (valid_i && !ready_o) drop = 1'b1;
      in_f  = valid_i && ready_o;
      out_f = valid_o && ready_i;
      if (out_f) begin
        if (n_out > 0 && cyc != last_cyc + 1) gap = 1'b1;
        last_cyc = cyc;
        n_out++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra: got tag=%h want no output", tag_o);
        end else begin
          e = exp_q.pop_front();
          if ({tag_o, state_o} !== e) begin
            errors++; $display("FAIL b2b_data: got %h want %h", {tag_o, state_o}, e);
          end
        end
      end
      if (in_f) begin
        exp_q.push_back({tag_i, (sent % 2 == 1) ? E2 : E1});
        sent++;
      end
      step();
    end
    set_in(1'b0, '0, '0, 1'b0, '0);
    checks += 3;
    if (n_out != 16) begin errors++; $display("FAIL b2b_count: got %0d want 16", n_out); end
    if (gap) begin errors++; $display("FAIL b2b_gap: got gap=1 want 0"); end
    if (drop) begin errors++; $display("FAIL b2b_ready_drop: got drop=1 want 0"); end
  endtask

  task automatic test_flush();
    logic seen;
    ready_i = 1'b0;
    set_in(1'b1, V1, K1, 1'b0, 4'h7);
    step();
    set_in(1'b1, V2, K2, 1'b1, 4'h8);
    step();
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL flush_full: got ready=%b want 0", ready_o); end
    set_in(1'b1, V1, K1, 1'b0, 4'h9);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    set_in(1'b0, '0, '0, 1'b0, '0);
    checks += 2;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", valid_o); end
    if (ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", ready_o); end
    ready_i = 1'b1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (valid_o) seen = 1'b1;
      step();
    end
    checks++;
    if (seen) begin errors++; $display("FAIL flush_leak: got valid output want none"); end
  endtask

  task automatic test_async_reset();
    ready_i = 1'b0;
    set_in(1'b1, V2, K2, 1'b1, 4'h3);
    step();
    set_in(1'b1, V1, K1, 1'b0, 4'h4);
    step();
    set_in(1'b0, '0, '0, 1'b0, '0);
    checks++;
    if (valid_o !== 1'b1) begin errors++; $display("FAIL arst_pre: got valid=%b want 1", valid_o); end
    #2;
    rst_i = 1'b1;
    #1;
    checks += 4;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", valid_o); end
    if (state_o !== 128'h0) begin errors++; $display("FAIL arst_state: got %h want 0", state_o); end
    if (tag_o !== '0) begin errors++; $display("FAIL arst_tag: got %h want 0", tag_o); end
    if (ready_o !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b want 1", ready_o); end
    @(negedge clk_i);
    step();
    rst_i = 1'b0;
    step();
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL arst_release: got %b want 0", valid_o); end
    test_round1();
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_round1();
    test_final();
    test_identity();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
